button_debouncer: RTL
=====================

# button_debouncer

Synchronises, debounces and edge-detects the two push buttons (BUT1, BUT2) of the iCE40HX8K-EVB board and packs the result into a 32-bit word for the Murax GPIO A read port. It sits between the board pins and `io_gpioA_read` of the SoC inside the board toplevel, running on the PLL-derived `io_mainClk`. Firmware polls the packed word and clears sticky state through one GPIO write bit.

## Interface
- `DEBOUNCE_CYCLES`, default 12000: consecutive cycles a synchronised input must differ from the debounced state before it is accepted; legal range 2..2^20. Counter width is clog2(DEBOUNCE_CYCLES+1).
- `ACTIVE_LOW`, default 1: 1 means pin level 0 means pressed; 0 means pin level 1 means pressed.
- `io_mainClk` in 1: the single clock; all state is on its rising edge.
- `io_asyncResetn` in 1: reset, asynchronous and active-low. Asserts asynchronously; deassertion is synchronous to `io_mainClk` in the toplevel.
- `io_buttons` in 2: raw button pins; bit 0 is BUT1, bit 1 is BUT2; asynchronous to the clock.
- `io_clear` in 1: level-sensitive clear of the sticky flags and counters; driven from a GPIO write bit.
- `io_pressed` out 2: debounced logical state; 1 means pressed.
- `io_pressPulse` out 2: one-cycle pulse when the debounced state goes to pressed.
- `io_releasePulse` out 2: one-cycle pulse when the debounced state goes to released.
- `io_gpioRead` out 32: packed status word, laid out as follows.
  - [1:0] = `io_pressed`
  - [3:2] = sticky press flags
  - [5:4] = sticky release flags
  - [7:6] = 0
  - [15:8] = BUT1 press count
  - [23:16] = BUT2 press count
  - [31:24] = 0

## Operation
- **Per-button pipeline:** the two buttons are independent and identical.
  - Two-flop synchroniser `s1` → `s2`. Reset value is the released pin level (1 if ACTIVE_LOW, else 0).
  - Logical sample is `smp = s2 XOR ACTIVE_LOW`.
- **Debounce state machine, per button, state = `stable` (RELEASED/PRESSED) plus `cnt`:**
  - If `smp == stable`: `cnt <= 0`.
  - If `smp != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - If `smp != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= smp`, `cnt <= 0`, and the matching pulse is registered high for one cycle.
  - Net effect: `stable` flips on the DEBOUNCE_CYCLES-th consecutive edge at which `smp != stable`. Any single agreeing sample restarts the count.
- **Sticky flags:** set on the same edge as the pulse. They stay set until `io_clear` is high.
- **Press counters:** 8-bit, increment on each press pulse, wrap 255 → 0. There is no release counter.
- **`io_clear` high at an edge:** zeroes all sticky flags and both counters. Clear wins over a simultaneous press or release on that edge; the event is not recorded. `io_pressed`, the pulses, `stable` and `cnt` are unaffected by clear.
- **Simultaneous events:** presses on both buttons in the same cycle update both counters independently.
- **`io_gpioRead`:** a pure repacking of registered state, with no extra register stage.
- **Reset (including mid-debounce):** all state returns to reset values, with no pulse on reset entry or exit.
  - `stable` = RELEASED, `cnt` = 0, synchronisers at the released pin level.
  - `io_pressed` = 0, pulses 0, flags 0, counters 0, `io_gpioRead` = 0.
  - A button held through reset is reported as a press DEBOUNCE_CYCLES+2 cycles after reset release.

## Timing
- **Pin to state latency:** a pin change set up before edge 1 is captured in `s1` at edge 1 and in `s2` at edge 2. `io_pressed` and the pulse update at edge DEBOUNCE_CYCLES+2, i.e. a latency of DEBOUNCE_CYCLES+2 cycles.
- **Flag and counter timing:** sticky flags and counters are visible in `io_gpioRead` in the same cycle as the pulse.
- **Clear timing:** `io_clear` sampled high at edge n gives zeroed flags and counters after edge n.
- **Pulse width:** exactly one cycle; pulses on the same button are at least DEBOUNCE_CYCLES cycles apart.
- **Glitch rejection:** glitches shorter than DEBOUNCE_CYCLES cycles, measured at `s2`, produce no state change.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4 and ACTIVE_LOW=1.
- **Reset:** hold `io_asyncResetn`=0 with `io_buttons`=2'b11. Required: all outputs 0. Release reset and idle 20 cycles: all outputs remain 0 and no pulses occur.
- **Clean press:** drive BUT1=0 before edge 1. Required: `io_pressPulse`[0]=1 only in the cycle after edge 6, `io_pressed`[0]=1 from edge 6, `io_gpioRead`=0x0000_0105. Release BUT1. Required: `io_releasePulse`[0] fires 6 cycles later and `io_gpioRead`=0x0000_0114.
- **Bounce rejection:** toggle BUT2 low for 3 cycles, high for 1 cycle, low for 2 cycles, then high. Required: no pulse, `io_pressed`[1] stays 0, and `cnt` returns to 0.
- **Counter wrap and simultaneity:** press both buttons together 256 times. Required: each pulse pair arrives in the same cycle, and after the 256th press both counters read 0 while flags [3:2]=2'b11.
- **Clear versus event:** assert `io_clear` on the same edge as a BUT1 press pulse. Required: the pulse is still seen, `io_pressed`[0]=1, flag[2]=0 and count=0. The next press gives count=1.
- **Reset mid-debounce:** hold BUT1 low for 3 cycles, then pulse reset. Required: outputs return to 0. With BUT1 still held, the press is reported 6 cycles after reset release.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Button/GPIO bundle between the board pins, firmware GPIO and the debouncer.
interface button_debouncer_if;
  logic [1:0]  io_buttons;
  logic        io_clear;
  logic [1:0]  io_pressed;
  logic [1:0]  io_pressPulse;
  logic [1:0]  io_releasePulse;
  logic [31:0] io_gpioRead;

  modport master (
    output io_buttons, io_clear,
    input  io_pressed, io_pressPulse, io_releasePulse, io_gpioRead
  );

  modport slave (
    input  io_buttons, io_clear,
    output io_pressed, io_pressPulse, io_releasePulse, io_gpioRead
  );
endinterface

// File: rtl/button_debouncer.sv
// Synchronises, debounces and edge-detects BUT1/BUT2 and packs sticky flags
// and press counters into the 32-bit Murax GPIO A read word.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input logic                io_mainClk,
  input logic                io_asyncResetn,
  button_debouncer_if.slave  bus
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_t;

  logic [1:0]  pressed;
  logic [1:0]  press_pulse;
  logic [1:0]  release_pulse;
  logic [1:0]  press_flag;
  logic [1:0]  release_flag;
  logic [15:0] press_count;

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic          s1, s2, smp;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_d, release_d;
    logic          press_q, release_q;
    logic          pflag_q, rflag_q;
    logic [7:0]    count_q;

    // Synchroniser idles at the released pin level so reset never looks like a press.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
        s1 <= ACTIVE_LOW;
        s2 <= ACTIVE_LOW;
      end else begin
        s1 <= bus.io_buttons[g];
        s2 <= s1;
      end
    end

    assign smp = s2 ^ ACTIVE_LOW;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (smp == logic'(state_q)) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_LAST) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        state_d   = state_t'(smp);
        cnt_d     = '0;
        press_d   = smp;
        release_d = ~smp;
      end
    end

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
        state_q   <= RELEASED;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        pflag_q   <= 1'b0;
        rflag_q   <= 1'b0;
        count_q   <= '0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        // Clear takes priority: an event landing on a clear edge is dropped.
        if (bus.io_clear) begin
          pflag_q <= 1'b0;
          rflag_q <= 1'b0;
          count_q <= '0;
        end else begin
          pflag_q <= pflag_q | press_d;
          rflag_q <= rflag_q | release_d;
          count_q <= count_q + {7'd0, press_d};
        end
      end
    end

    assign pressed[g]             = (state_q == PRESSED);
    assign press_pulse[g]         = press_q;
    assign release_pulse[g]       = release_q;
    assign press_flag[g]          = pflag_q;
    assign release_flag[g]        = rflag_q;
    assign press_count[g*8 +: 8]  = count_q;
  end

  assign bus.io_pressed      = pressed;
  assign bus.io_pressPulse   = press_pulse;
  assign bus.io_releasePulse = release_pulse;
  assign bus.io_gpioRead     = {8'h00, press_count, 2'b00, release_flag, press_flag, pressed};

endmodule
